sprite_mapper: RTL



---
 rtl/sprite_pkg.sv | 29 ++
 rtl/font_rom.sv | 14 +
 rtl/sprite_hit.sv | 47 ++++
 rtl/sprite_mapper.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite types, geometry constants and scale helper for the sprite mapper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sprite_pkg;

    // Position fields are stored at the widest supported coordinate width;
    // users take the low COORD_W bits.
    localparam int COORD_MAX = 16;

    localparam int         GLYPH_W     = 8;
    localparam int         GLYPH_H     = 16;
    localparam logic [7:0] BG_RED_BASE = 8'h4f;
    localparam logic [7:0] BG_BLUE     = 8'h44;

    typedef struct packed {
        logic                 en;
        logic [COORD_MAX-1:0] x;
        logic [COORD_MAX-1:0] y;
        logic [6:0]           code;
        logic [1:0]           scale;
        logic [23:0]          rgb;
    } sprite_t;

    // Scale code 3 behaves as scale 2 (4x).
    function automatic logic [1:0] clamp_scale(input logic [1:0] scale);
        return (scale == 2'd3) ? 2'd2 : scale;
    endfunction

endpackage

// File: rtl/font_rom.sv
// Glyph bitmap ROM: 128 codes x 16 rows x 8 pixels, addressed {code, row}; bit 7 is the leftmost pixel.
// Latency: combinational read.
// Backpressure: none.
module font_rom (
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    // Bitmap contents are an address-derived pattern.
    always_comb begin
        data = {addr[3:0], addr[7:4]} ^ addr[10:3];
    end

endmodule

// File: rtl/sprite_hit.sv
// Bounding-box hit test of one sprite slot against the current pixel, with glyph column/row.
// Latency: combinational.
// Backpressure: none.
module sprite_hit
    import sprite_pkg::*;
#(
    parameter int COORD_W = 10
) (
    input  sprite_t            spr,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    output logic               hit,
    output logic [2:0]         col,
    output logic [3:0]         row
);

    localparam int CW1 = COORD_W + 1;

    logic [COORD_W-1:0] spr_x;
    logic [COORD_W-1:0] spr_y;
    logic [1:0]         s;
    logic [COORD_W:0]   dx;
    logic [COORD_W:0]   dy;
    logic [COORD_W:0]   width;
    logic [COORD_W:0]   height;
    logic               unused_fields;

    // Only the position, scale and enable matter here; the rest is consumed by the top.
    assign unused_fields = ^{spr.x, spr.y, spr.code, spr.rgb};

    // Offsets are one bit wider than the coordinates and gated by the >= tests,
    // so sprites hanging past the coordinate limit never wrap back to column 0.
    always_comb begin
        spr_x  = COORD_W'(spr.x);
        spr_y  = COORD_W'(spr.y);
        s      = clamp_scale(spr.scale);
        dx     = {1'b0, draw_x} - {1'b0, spr_x};
        dy     = {1'b0, draw_y} - {1'b0, spr_y};
        width  = CW1'(GLYPH_W) << s;
        height = CW1'(GLYPH_H) << s;
        hit    = spr.en && (draw_x >= spr_x) && (draw_y >= spr_y) &&
                 (dx < width) && (dy < height);
        col    = 3'(dx >> s);
        row    = 4'(dy >> s);
    end

endmodule

// File: rtl/sprite_mapper.sv
// Multi-sprite pixel mapper: shadow/active sprite tables, priority glyph render, per-frame collision flags.
// Latency: 2 cycles DrawX/DrawY/pix_valid -> RGB/out_valid, 1 pixel per cycle.
// Backpressure: wr_ready drops only on frame_start (table commit) and in reset; pixel path never stalls.
module sprite_mapper
    import sprite_pkg::*;
#(
    parameter  int NUM_SPRITES = 4,
    parameter  int COORD_W     = 10,
    localparam int IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_start,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [COORD_W-1:0]     wr_x,
    input  logic [COORD_W-1:0]     wr_y,
    input  logic [6:0]             wr_code,
    input  logic [1:0]             wr_scale,
    input  logic [23:0]            wr_rgb,
    input  logic                   wr_en,
    input  logic                   pix_valid,
    input  logic [COORD_W-1:0]     DrawX,
    input  logic [COORD_W-1:0]     DrawY,
    output logic [7:0]             Red,
    output logic [7:0]             Green,
    output logic [7:0]             Blue,
    output logic                   out_valid,
    output logic                   collision,
    output logic [NUM_SPRITES-1:0] collision_mask
);

    sprite_t shadow_tbl [NUM_SPRITES];
    sprite_t active_tbl [NUM_SPRITES];
    logic    rdy_q;

    logic [NUM_SPRITES-1:0] hit_vec;
    logic [2:0]             col_vec [NUM_SPRITES];
    logic [3:0]             row_vec [NUM_SPRITES];
    logic                   multi_hit;

    logic        win_hit;
    logic [23:0] win_rgb;
    logic [2:0]  win_col;
    logic [10:0] win_addr;

    logic        s1_vld;
    logic        s1_hit;
    logic [23:0] s1_rgb;
    logic [2:0]  s1_col;
    logic [10:0] s1_addr;
    logic [6:0]  s1_bgx;

    logic [15:0] draw_x_ext;
    logic        unused_x_bits;
    logic [7:0]  rom_data;
    logic        fg;
    logic [7:0]  bg_red;

    // A write offered during the commit cycle is refused so it cannot slip into the commit.
    assign wr_ready = rdy_q & ~frame_start;

    // Shadow table takes writes; active table reloads from it atomically at frame start.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            rdy_q <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_tbl[i] <= '0;
                active_tbl[i] <= '0;
            end
        end else begin
            rdy_q <= 1'b1;
            if (frame_start) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    active_tbl[i] <= shadow_tbl[i];
                end
            end
            if (wr_valid && wr_ready && (int'(wr_idx) < NUM_SPRITES)) begin
                shadow_tbl[wr_idx] <= '{en:    wr_en,
                                        x:     COORD_MAX'(wr_x),
                                        y:     COORD_MAX'(wr_y),
                                        code:  wr_code,
                                        scale: wr_scale,
                                        rgb:   wr_rgb};
            end
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit #(.COORD_W(COORD_W)) u_hit (
            .spr    (active_tbl[g]),
            .draw_x (DrawX),
            .draw_y (DrawY),
            .hit    (hit_vec[g]),
            .col    (col_vec[g]),
            .row    (row_vec[g])
        );
    end

    // Two or more bits set in the hit vector.
    assign multi_hit = |(hit_vec & (hit_vec - NUM_SPRITES'(1)));

    // Lowest-index hitting slot wins: scan high to low so lower indices overwrite.
    always_comb begin
        win_hit  = 1'b0;
        win_rgb  = '0;
        win_col  = '0;
        win_addr = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_hit  = 1'b1;
                win_rgb  = active_tbl[i].rgb;
                win_col  = col_vec[i];
                win_addr = {active_tbl[i].code, row_vec[i]};
            end
        end
    end

    assign draw_x_ext    = 16'(DrawX);
    assign unused_x_bits = ^{draw_x_ext[15:10], draw_x_ext[2:0]};

    // Stage 1: register the winner and update the sticky collision flags (set beats clear).
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            s1_vld         <= 1'b0;
            s1_hit         <= 1'b0;
            s1_rgb         <= '0;
            s1_col         <= '0;
            s1_addr        <= '0;
            s1_bgx         <= '0;
            collision      <= 1'b0;
            collision_mask <= '0;
        end else begin
            s1_vld  <= pix_valid;
            s1_hit  <= win_hit;
            s1_rgb  <= win_rgb;
            s1_col  <= win_col;
            s1_addr <= win_addr;
            s1_bgx  <= draw_x_ext[9:3];
            if (frame_start) begin
                collision      <= 1'b0;
                collision_mask <= '0;
            end
            if (pix_valid && multi_hit) begin
                collision      <= 1'b1;
                collision_mask <= (frame_start ? '0 : collision_mask) | hit_vec;
            end
        end
    end

    font_rom u_rom (
        .addr (s1_addr),
        .data (rom_data)
    );

    // ROM zero bits are transparent down to the background, never to a lower-priority sprite.
    assign fg     = s1_hit & rom_data[3'd7 - s1_col];
    assign bg_red = BG_RED_BASE - {1'b0, s1_bgx};

    // Stage 2: register the final colour, blanked outside the visible region.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            out_valid <= 1'b0;
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
        end else begin
            out_valid <= s1_vld;
            if (!s1_vld) begin
                {Red, Green, Blue} <= '0;
            end else if (fg) begin
                {Red, Green, Blue} <= s1_rgb;
            end else begin
                {Red, Green, Blue} <= {bg_red, 8'h00, BG_BLUE};
            end
        end
    end

endmodule
